// File: rtl/vram_arbiter_if.sv
// Frame-buffer arbiter bus: scan position, two writer ports, RAM port and pixel output.
// The arbiter takes the slave view; the counter/writer/RAM environment takes the master view.
interface vram_arbiter_if;
    logic [9:0]  HControl;
    logic [9:0]  VControl;
    logic        wr_req_a;
    logic [14:0] wr_addr_a;
    logic [7:0]  wr_data_a;
    logic        wr_ack_a;
    logic        wr_req_b;
    logic [14:0] wr_addr_b;
    logic [7:0]  wr_data_b;
    logic        wr_ack_b;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  pixel_out;

    modport slave (
        input  HControl, VControl,
        input  wr_req_a, wr_addr_a, wr_data_a,
        input  wr_req_b, wr_addr_b, wr_data_b,
        input  mem_rdata,
        output wr_ack_a, wr_ack_b,
        output mem_addr, mem_we, mem_wdata,
        output pixel_out
    );

    modport master (
        output HControl, VControl,
        output wr_req_a, wr_addr_a, wr_data_a,
        output wr_req_b, wr_addr_b, wr_data_b,
        output mem_rdata,
        input  wr_ack_a, wr_ack_b,
        input  mem_addr, mem_we, mem_wdata,
        input  pixel_out
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares the 160x120 frame-buffer RAM between display scan-out and two round-robin writers.
// Define VRAM_ARB_HBLANK_WR_EN to also open the write window in horizontal blanking.
module vram_arbiter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525
) (
    input  logic          normalCLK,
    input  logic          reset,
    vram_arbiter_if.slave bus
);
    localparam logic [9:0]  H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [14:0] ADDR_LIMIT = 15'd19200;

    typedef enum logic [0:0] {IDLE = 1'b0, WRITE = 1'b1} state_t;

    state_t      state_r, state_s;
    logic        last_b_r, last_b_s;
    logic [9:0]  h_next_s, v_next_s;
    logic        active_next_s, window_s;
    logic [14:0] rd_addr_s, wr_addr_sel_s;
    logic [7:0]  wr_data_sel_s;
    logic        grant_s, sel_b_s;
    logic [14:0] mem_addr_r, mem_addr_s;
    logic        mem_we_r, mem_we_s;
    logic [7:0]  mem_wdata_r, mem_wdata_s;
    logic        ack_a_r, ack_a_s, ack_b_r, ack_b_s;
    logic        act1_r, act2_r;
    logic [7:0]  pixel_r;

    // Look-ahead position: everything registered this cycle belongs to the next position.
    always_comb begin
        if (bus.HControl == H_LAST) begin
            h_next_s = 10'd0;
            if (bus.VControl == V_LAST) begin
                v_next_s = 10'd0;
            end else begin
                v_next_s = bus.VControl + 10'd1;
            end
        end else begin
            h_next_s = bus.HControl + 10'd1;
            v_next_s = bus.VControl;
        end
    end

    assign active_next_s = (h_next_s < H_ACT) && (v_next_s < V_ACT);
    assign rd_addr_s     = ({7'd0, v_next_s[9:2]} * 15'd160) + {7'd0, h_next_s[9:2]};

`ifdef VRAM_ARB_HBLANK_WR_EN
    assign window_s = !active_next_s;
`else
    assign window_s = !active_next_s && (v_next_s >= V_ACT);
`endif

    assign wr_addr_sel_s = sel_b_s ? bus.wr_addr_b : bus.wr_addr_a;
    assign wr_data_sel_s = sel_b_s ? bus.wr_data_b : bus.wr_data_a;

    // Next state, round-robin choice and next values of the registered RAM port.
    always_comb begin
        state_s     = state_r;
        last_b_s    = last_b_r;
        grant_s     = 1'b0;
        sel_b_s     = 1'b0;
        mem_addr_s  = mem_addr_r;
        mem_we_s    = 1'b0;
        mem_wdata_s = mem_wdata_r;
        ack_a_s     = 1'b0;
        ack_b_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (window_s && (bus.wr_req_a || bus.wr_req_b)) begin
                    grant_s = 1'b1;
                    state_s = WRITE;
                    if (bus.wr_req_a && bus.wr_req_b) begin
                        sel_b_s = !last_b_r;
                    end else begin
                        sel_b_s = bus.wr_req_b;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WRITE:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
        // A grant can only happen in an inactive slot, so it never competes with a read.
        if (grant_s) begin
            last_b_s    = sel_b_s;
            mem_addr_s  = wr_addr_sel_s;
            mem_wdata_s = wr_data_sel_s;
            mem_we_s    = (wr_addr_sel_s < ADDR_LIMIT);
            ack_a_s     = !sel_b_s;
            ack_b_s     = sel_b_s;
        end else if (active_next_s) begin
            mem_addr_s = rd_addr_s;
        end else begin
            mem_addr_s = mem_addr_r;
        end
    end

    // State, pointer and RAM-port registers; reset abandons any write in flight.
    always_ff @(posedge normalCLK or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            last_b_r    <= 1'b1;
            mem_addr_r  <= 15'd0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= 8'd0;
            ack_a_r     <= 1'b0;
            ack_b_r     <= 1'b0;
        end else begin
            state_r     <= state_s;
            last_b_r    <= last_b_s;
            mem_addr_r  <= mem_addr_s;
            mem_we_r    <= mem_we_s;
            mem_wdata_r <= mem_wdata_s;
            ack_a_r     <= ack_a_s;
            ack_b_r     <= ack_b_s;
        end
    end

    // Two-stage active flag follows each read through the RAM latency to the pixel register.
    always_ff @(posedge normalCLK or posedge reset) begin
        if (reset) begin
            act1_r  <= 1'b0;
            act2_r  <= 1'b0;
            pixel_r <= 8'd0;
        end else begin
            act1_r  <= active_next_s;
            act2_r  <= act1_r;
            pixel_r <= act2_r ? bus.mem_rdata : 8'd0;
        end
    end

    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.wr_ack_a  = ack_a_r;
    assign bus.wr_ack_b  = ack_b_r;
    assign bus.pixel_out = pixel_r;
endmodule
